uu_acmac_mem_tx_dp: RTL and testbench
=====================================

Name: uu_acmac_mem_tx_dp

Overview:
Parametrised dual-port TX frame buffer for the ACMAC datapath.
- Port A is the host/CP side: read and write, with byte enables.
- Port B is the MAC transmit side: read-only.
- Configurable width, depth and read latency.
- Self-clears its contents after reset and flags out-of-range or not-ready accesses.

Parameters:
- DATA_W, 8: data width in bits; must be a multiple of 8.
- ADDR_W, 8: address width; 2**ADDR_W must be >= DEPTH.
- DEPTH, 208: number of words.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2.
- NUM_BE, DATA_W/8: number of byte-enable bits (derived; do not override).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- init_done  out  1  high once memory clear is complete
- a_en  in  1  port A access enable
- a_wen  in  1  port A write enable (1 = write, 0 = read)
- a_be  in  NUM_BE  port A byte enables for writes
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data
- a_err  out  1  port A error, aligned with a_rdata
- b_en  in  1  port B read enable
- b_addr  in  ADDR_W  port B address
- b_rdata  out  DATA_W  port B read data
- b_err  out  1  port B error, aligned with b_rdata

Behaviour:
- Clocking and reset
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset: FSM enters INIT, clear counter = 0, init_done = 0.
  - On reset: a_rdata, b_rdata, a_err and b_err are 0, and all pipeline stages are flushed.
- FSM states
  - INIT: writes 0 to word[clr_cnt] each cycle, then clr_cnt increments.
  - INIT -> READY: when clr_cnt == DEPTH-1, after that word is written. The clear therefore takes exactly DEPTH cycles.
  - init_done goes 1 on the first READY cycle and stays 1 until rst.
  - READY is held until rst. No other transitions exist.
- Access during INIT
  - Any en=1 access is ignored: no write, rdata = 0, err = 1 at normal latency.
- Port A in READY
  - a_en=0: a_rdata = 0 and a_err = 0 at latency RD_LAT.
  - a_en=1, a_wen=0: a_rdata = word[a_addr].
  - a_en=1, a_wen=1: read-before-write. a_rdata returns the old word. Only byte lanes with a_be[i]=1 are updated; a_be = 0 writes nothing but still reads.
- Port B in READY
  - b_en=1: b_rdata = word[b_addr].
  - b_en=0: b_rdata = 0.
- Collision
  - Port A write and port B read to the same address in the same cycle: port B returns the OLD data. The new data is visible from the next cycle's access.
- Out of range (addr >= DEPTH)
  - Write is dropped, rdata = 0, err = 1. err is aligned with the data and is a single-cycle pulse per access.
  - There is no address wrap.
- Latency
  - RD_LAT=1: data and err are registered and valid in cycle N+1 for an access in cycle N.
  - RD_LAT=2: one extra output register, valid in cycle N+2.
  - Back-to-back accesses sustain one result per cycle on each port, fully pipelined with no bubbles.
- Reset mid-operation
  - Reset during INIT or READY restarts the clear from word 0.
  - In-flight reads are discarded and their outputs forced to 0.
- Word order within a word: byte lane i is bits [8i+7:8i].

Decomposition:
- Package uu_acmac_mem_pkg holds:
  - the state enum (ST_INIT, ST_READY);
  - the default DATA_W/ADDR_W/DEPTH constants;
  - the legal RD_LAT range check constant.
- One sub-module, uu_acmac_rd_pipe, instantiated once per port.
  - Parameters: DATA_W, RD_LAT.
  - Carries {rdata, err} through 1 or 2 stages.
  - Synchronously cleared on rst.
- The memory array, clear FSM and range checks live in the top module.

Test Plan:
1. Init clear: assert rst for 1 cycle, then release.
   -> init_done rises exactly DEPTH (208) cycles later.
   -> A port-B read at any address (e.g. 207) then returns 0x00 with b_err = 0.
2. Access during INIT: a_en=1, a_wen=1, addr 5, data 0xAA issued in the 3rd INIT cycle.
   -> a_err = 1 and a_rdata = 0 at RD_LAT.
   -> After init, a read of addr 5 returns 0x00.
3. Read-before-write and byte enables (DATA_W=16): write 0x1234 to addr 10 with be=11, then write 0xABCD with be=01.
   -> The second write returns 0x1234.
   -> A subsequent read returns 0x12CD.
4. Collision: same cycle A writes 0x55 to addr 20 (old value 0x11) and B reads addr 20.
   -> b_rdata = 0x11.
   -> The next-cycle B read = 0x55.
5. Out of range: A writes 0x77 to addr 208, and B reads addr 255.
   -> a_err = 1, b_err = 1, both rdata = 0.
   -> Addr 0 is unchanged (no wrap).
6. Latency and reset mid-op with RD_LAT=2: streaming B reads of addrs 0..3 -> data appears at cycles N+2..N+5. Asserting rst at N+3 -> b_rdata = 0 from N+4 and init restarts (init_done = 0).

Source files
------------

// File: rtl/uu_acmac_mem_pkg.sv
// Shared types and defaults for the ACMAC TX frame buffer.
package uu_acmac_mem_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 208;

    // Supported read latencies; anything above the maximum is clamped to it.
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/uu_acmac_rd_pipe.sv
// Read-result pipeline: carries {rdata, err} through one or two register stages.
module uu_acmac_rd_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              err_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    logic [DATA_W-1:0] s1_rdata_q;
    logic              s1_err_q;

    // First stage, always present.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rdata_q <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_rdata_q <= rdata_i;
            s1_err_q   <= err_i;
        end
    end

    if (RD_LAT >= 2) begin : g_lat2
        logic [DATA_W-1:0] s2_rdata_q;
        logic              s2_err_q;

        // Second output stage for the two-cycle configuration.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_rdata_q <= '0;
                s2_err_q   <= 1'b0;
            end else begin
                s2_rdata_q <= s1_rdata_q;
                s2_err_q   <= s1_err_q;
            end
        end

        assign rdata_o = s2_rdata_q;
        assign err_o   = s2_err_q;
    end else begin : g_lat1
        assign rdata_o = s1_rdata_q;
        assign err_o   = s1_err_q;
    end

endmodule

// File: rtl/uu_acmac_mem_tx_dp.sv
// Dual-port TX frame buffer: host R/W port A, MAC read-only port B, self-clearing after reset.
module uu_acmac_mem_tx_dp
    import uu_acmac_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned NUM_BE = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              a_en,
    input  logic              a_wen,
    input  logic [NUM_BE-1:0] a_be,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err
);

    localparam int unsigned PIPE_LAT = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

    mem_state_e        state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              init_done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready_c;
    logic              a_in_rng_c;
    logic              b_in_rng_c;
    logic              a_wr_c;
    logic [DATA_W-1:0] a_rdata_c;
    logic              a_err_c;
    logic [DATA_W-1:0] b_rdata_c;
    logic              b_err_c;

    assign ready_c    = (state_q == ST_READY);
    assign a_in_rng_c = (32'(a_addr) < DEPTH);
    assign b_in_rng_c = (32'(b_addr) < DEPTH);
    assign a_wr_c     = ready_c && a_en && a_wen && a_in_rng_c && !rst;

    // Clear sequencer: walk every word once, then stay READY until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    // Storage: zero-fill during INIT, byte-lane writes from port A when READY.
    always_ff @(posedge clk) begin
        if (!ready_c) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (a_wr_c) begin
            for (int unsigned i = 0; i < NUM_BE; i++) begin
                if (a_be[i]) begin
                    mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // Pre-write read of both ports; this gives read-before-write on A and old data on B collisions.
    always_comb begin
        a_rdata_c = '0;
        a_err_c   = 1'b0;
        b_rdata_c = '0;
        b_err_c   = 1'b0;
        if (a_en) begin
            if (!ready_c || !a_in_rng_c) begin
                a_err_c = 1'b1;
            end else begin
                a_rdata_c = mem_q[a_addr];
            end
        end
        if (b_en) begin
            if (!ready_c || !b_in_rng_c) begin
                b_err_c = 1'b1;
            end else begin
                b_rdata_c = mem_q[b_addr];
            end
        end
    end

    uu_acmac_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (PIPE_LAT)
    ) u_a_pipe (
        .clk     (clk),
        .rst     (rst),
        .rdata_i (a_rdata_c),
        .err_i   (a_err_c),
        .rdata_o (a_rdata),
        .err_o   (a_err)
    );

    uu_acmac_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (PIPE_LAT)
    ) u_b_pipe (
        .clk     (clk),
        .rst     (rst),
        .rdata_i (b_rdata_c),
        .err_i   (b_err_c),
        .rdata_o (b_rdata),
        .err_o   (b_err)
    );

    assign init_done = init_done_q;

endmodule

// File: tb/tb_uu_acmac_mem_tx_dp.sv
// Bench: an 8-bit/RD_LAT=1 buffer and a 16-bit/RD_LAT=2 buffer share one stimulus
// stream; the 8-bit one sees byte lane 0 only, so a single 16-bit model predicts both.
module tb_uu_acmac_mem_tx_dp;

    localparam int unsigned DEPTH = 208;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_wen, b_en;
    logic [1:0]  a_be;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata;

    logic        done1, a1_err, b1_err;
    logic [7:0]  a1_rdata, b1_rdata;
    logic        done2, a2_err, b2_err;
    logic [15:0] a2_rdata, b2_rdata;

    always #5 clk = ~clk;

    uu_acmac_mem_tx_dp #(
        .DATA_W (8), .ADDR_W (8), .DEPTH (DEPTH), .RD_LAT (1)
    ) u_dut1 (
        .clk (clk), .rst (rst), .init_done (done1),
        .a_en (a_en), .a_wen (a_wen), .a_be (a_be[0]), .a_addr (a_addr),
        .a_wdata (a_wdata[7:0]), .a_rdata (a1_rdata), .a_err (a1_err),
        .b_en (b_en), .b_addr (b_addr), .b_rdata (b1_rdata), .b_err (b1_err)
    );

    uu_acmac_mem_tx_dp #(
        .DATA_W (16), .ADDR_W (8), .DEPTH (DEPTH), .RD_LAT (2)
    ) u_dut2 (
        .clk (clk), .rst (rst), .init_done (done2),
        .a_en (a_en), .a_wen (a_wen), .a_be (a_be), .a_addr (a_addr),
        .a_wdata (a_wdata), .a_rdata (a2_rdata), .a_err (a2_err),
        .b_en (b_en), .b_addr (b_addr), .b_rdata (b2_rdata), .b_err (b2_err)
    );

    // Reference model: contents, cycles since reset, and per-edge access results.
    logic [15:0] mem_m [DEPTH];
    int          cyc_m;
    logic [15:0] ca_d, cb_d, pa_d, pb_d;
    logic        ca_e, cb_e, pa_e, pb_e;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive, advance the model at the edge, compare both DUTs just after it.
    task automatic step(input logic r, input logic ae, input logic aw, input logic [1:0] abe,
                        input logic [7:0] aa, input logic [15:0] ad,
                        input logic ben, input logic [7:0] ba);
        logic rdy;
        rst = r; a_en = ae; a_wen = aw; a_be = abe; a_addr = aa; a_wdata = ad;
        b_en = ben; b_addr = ba;
        @(posedge clk);
        pa_d = ca_d; pa_e = ca_e; pb_d = cb_d; pb_e = cb_e;
        ca_d = '0; ca_e = 1'b0; cb_d = '0; cb_e = 1'b0;
        if (r) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
            cyc_m = 0;
            pa_d = '0; pa_e = 1'b0; pb_d = '0; pb_e = 1'b0;
        end else begin
            rdy = (cyc_m >= int'(DEPTH));
            if (ae) begin
                if (!rdy || aa >= DEPTH) ca_e = 1'b1;
                else                     ca_d = mem_m[aa];
            end
            if (ben) begin
                if (!rdy || ba >= DEPTH) cb_e = 1'b1;
                else                     cb_d = mem_m[ba];
            end
            if (rdy && ae && aw && aa < DEPTH) begin
                if (abe[0]) mem_m[aa][7:0]  = ad[7:0];
                if (abe[1]) mem_m[aa][15:8] = ad[15:8];
            end
            if (cyc_m < int'(DEPTH)) cyc_m++;
        end
        #1;
        chk("done1",  32'(done1),    32'(cyc_m >= int'(DEPTH)));
        chk("done2",  32'(done2),    32'(cyc_m >= int'(DEPTH)));
        chk("a_rd1",  32'(a1_rdata), 32'(ca_d[7:0]));
        chk("a_err1", 32'(a1_err),   32'(ca_e));
        chk("b_rd1",  32'(b1_rdata), 32'(cb_d[7:0]));
        chk("b_err1", 32'(b1_err),   32'(cb_e));
        chk("a_rd2",  32'(a2_rdata), 32'(pa_d));
        chk("a_err2", 32'(a2_err),   32'(pa_e));
        chk("b_rd2",  32'(b2_rdata), 32'(pb_d));
        chk("b_err2", 32'(b2_err),   32'(pb_e));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b0, 8'd0);
    endtask

    initial begin
        ca_d = '0; cb_d = '0; ca_e = 1'b0; cb_e = 1'b0; cyc_m = 0;
        rst = 1'b1; a_en = 1'b0; a_wen = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_addr = '0;
        @(negedge clk);

        // Reset, then the clear sequence with a write attempt in the 3rd INIT cycle.
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b0, 8'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_a_err", 32'(a1_err), 32'd0);
        for (int k = 1; k <= 207; k++) begin
            if (k == 3) begin
                step(1'b0, 1'b1, 1'b1, 2'b11, 8'd5, 16'h00AA, 1'b0, 8'd0);
                chk("init_a_err", 32'(a1_err), 32'd1);
                chk("init_a_rd", 32'(a1_rdata), 32'd0);
            end else begin
                idle();
            end
        end
        chk("done_early", 32'(done1), 32'd0);
        idle();
        chk("done_208", 32'(done1), 32'd1);

        // Cleared contents, and the INIT write was dropped.
        step(1'b0, 1'b1, 1'b0, 2'b00, 8'd5, 16'h0, 1'b1, 8'd207);
        chk("t2_rd5", 32'(a1_rdata), 32'd0);
        chk("t1_b207", 32'(b1_rdata), 32'd0);
        chk("t1_berr", 32'(b1_err), 32'd0);

        // Read-before-write and byte enables.
        step(1'b0, 1'b1, 1'b1, 2'b11, 8'd10, 16'h1234, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 2'b01, 8'd10, 16'hABCD, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 8'd10, 16'h0, 1'b0, 8'd0);
        chk("t3_rbw", 32'(a2_rdata), 32'h1234);
        chk("t3_lo8", 32'(a1_rdata), 32'hCD);
        idle();
        chk("t3_be", 32'(a2_rdata), 32'h12CD);

        // Same-address collision: B sees the old word.
        step(1'b0, 1'b1, 1'b1, 2'b11, 8'd20, 16'h0011, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 2'b11, 8'd20, 16'h0055, 1'b1, 8'd20);
        chk("t4_col", 32'(b1_rdata), 32'h11);
        step(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd20);
        chk("t4_new", 32'(b1_rdata), 32'h55);

        // Out-of-range on both ports, no wrap into word 0.
        step(1'b0, 1'b1, 1'b1, 2'b11, 8'd208, 16'h0077, 1'b1, 8'd255);
        chk("t5_aerr", 32'(a1_err), 32'd1);
        chk("t5_berr", 32'(b1_err), 32'd1);
        chk("t5_ard", 32'(a1_rdata), 32'd0);
        chk("t5_brd", 32'(b1_rdata), 32'd0);
        step(1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 16'h0, 1'b0, 8'd0);
        chk("t5_errpulse", 32'(a1_err), 32'd0);
        chk("t5_nowrap", 32'(a1_rdata), 32'd0);

        // Streaming B reads on the two-stage port, then reset mid-stream.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, 2'b11, 8'(i), 16'h00A0 + 16'(i), 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd1);
        chk("t6_b0", 32'(b2_rdata), 32'h00A0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd2);
        chk("t6_b1", 32'(b2_rdata), 32'h00A1);
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd3);
        chk("t6_flush", 32'(b2_rdata), 32'd0);
        chk("t6_done", 32'(done2), 32'd0);

        // Randomized traffic with occasional resets, including accesses during INIT.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] aa, ba;
            aa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            ba = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 15));
            step(($urandom_range(0, 599) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
                 aa, 16'($urandom), 1'($urandom), ba);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
